// File: rtl/opcode_trace_decoder.sv
// Opcode trace decoder: turns executed 4-bit opcodes back into their ASCII
// source symbols, buffers them in a first-word-fall-through FIFO and streams
// them to the console sink over valid/ready. A newline is inserted after every
// HALT symbol and after every LINE_LEN symbols on a line (LINE_LEN=0 disables
// the length-based breaks).
module opcode_trace_decoder #(
  parameter int DEPTH    = 8,
  parameter int LINE_LEN = 64
) (
  input  logic                     CLOCK,
  input  logic                     RST_N,
  input  logic                     OP_VALID,
  input  logic [3:0]               OPCODE,
  output logic                     OP_READY,
  output logic                     SYM_VALID,
  input  logic                     SYM_READY,
  output logic [7:0]               SYMBOL,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     OVERFLOW,
  input  logic                     OVF_CLR
);

  localparam int AW    = $clog2(DEPTH);
  localparam int COL_W = (LINE_LEN > 1) ? $clog2(LINE_LEN + 1) : 1;

  typedef enum logic {
    SYM,
    NL
  } traceStateT;

  logic [7:0]       fifoMem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic [COL_W-1:0] column;
  logic [COL_W-1:0] columnNext;
  traceStateT       state;
  traceStateT       stateNext;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             drop;
  logic             lineDone;
  logic [7:0]       pushSym;
  logic [7:0]       headSym;

  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign OP_READY = !full;
  assign push     = OP_VALID && !full && (OPCODE != 4'd0);
  assign drop     = OP_VALID && full;
  assign headSym  = fifoMem[rdPtr];
  assign LEVEL    = count;
  assign lineDone = (LINE_LEN != 0) &&
                    (({1'b0, column} + (COL_W + 1)'(1)) == (COL_W + 1)'(LINE_LEN));

  // Decode the incoming opcode into the ASCII symbol that gets stored
  always_comb begin
    pushSym = 8'h3F;
    case (OPCODE)
      4'd0:    pushSym = 8'h00;
      4'd1:    pushSym = 8'h2B;
      4'd2:    pushSym = 8'h2D;
      4'd3:    pushSym = 8'h3E;
      4'd4:    pushSym = 8'h3C;
      4'd5:    pushSym = 8'h5B;
      4'd6:    pushSym = 8'h5D;
      4'd7:    pushSym = 8'h2E;
      4'd8:    pushSym = 8'h2C;
      4'd9:    pushSym = 8'h23;
      default: pushSym = 8'h3F;
    endcase
  end

  // Symbol storage; contents need no reset because occupancy gates every read
  always_ff @(posedge CLOCK) begin
    if (push) begin
      fifoMem[wrPtr] <= pushSym;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2
  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      OVERFLOW <= 1'b0;
    end else if (drop) begin
      OVERFLOW <= 1'b1;
    end else if (OVF_CLR) begin
      OVERFLOW <= 1'b0;
    end
  end

  // Output FSM state and column register
  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= SYM;
      column <= '0;
    end else begin
      state  <= stateNext;
      column <= columnNext;
    end
  end

  // Output FSM: present the FIFO head, or a newline while in NL
  always_comb begin
    stateNext  = state;
    columnNext = column;
    SYM_VALID  = 1'b0;
    SYMBOL     = 8'h00;
    pop        = 1'b0;
    case (state)
      SYM: begin
        SYM_VALID = !empty;
        if (!empty) begin
          SYMBOL = headSym;
          if (SYM_READY) begin
            pop = 1'b1;
            if (headSym == 8'h23) begin
              stateNext = NL;
            end else if (lineDone) begin
              stateNext = NL;
            end else begin
              columnNext = column + COL_W'(1);
            end
          end
        end
      end
      NL: begin
        SYM_VALID = 1'b1;
        SYMBOL    = 8'h0A;
        if (SYM_READY) begin
          stateNext  = SYM;
          columnNext = '0;
        end
      end
      default: begin
        stateNext = SYM;
      end
    endcase
  end

endmodule

// File: tb/tb_opcode_trace_decoder.sv
// Testbench for opcode_trace_decoder: randomized and directed stimulus checked
// against a queue-based reference model of the trace stream.
module tb_opcode_trace_decoder;

  localparam int DEPTH = 8;
  localparam int LL    = 64;
  localparam int LL2   = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          rstN  = 1'b1;

  logic          opValid = 1'b0;
  logic [3:0]    opcode  = 4'd0;
  logic          symReady = 1'b0;
  logic          ovfClr  = 1'b0;
  logic          opReady;
  logic          symValid;
  logic [7:0]    symbol;
  logic [LW-1:0] level;
  logic          overflow;

  logic          op2Valid  = 1'b0;
  logic [3:0]    opcode2   = 4'd0;
  logic          sym2Ready = 1'b0;
  logic          ovf2Clr   = 1'b0;
  logic          op2Ready;
  logic          sym2Valid;
  logic [7:0]    symbol2;
  logic [LW-1:0] level2;
  logic          overflow2;

  int testsRun    = 0;
  int testsFailed = 0;

  byte unsigned symTable [16] = '{8'h00, 8'h2B, 8'h2D, 8'h3E, 8'h3C, 8'h5B, 8'h5D, 8'h2E,
                                  8'h2C, 8'h23, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};

  byte unsigned modelQ[$];
  byte unsigned modelOut[$];
  byte unsigned dutOut[$];
  byte unsigned expQ[$];
  int           modelCol = 0;
  bit           modelNl  = 1'b0;
  bit           modelOvf = 1'b0;

  opcode_trace_decoder #(.DEPTH(DEPTH), .LINE_LEN(LL)) dut (
    .CLOCK(clock), .RST_N(rstN), .OP_VALID(opValid), .OPCODE(opcode),
    .OP_READY(opReady), .SYM_VALID(symValid), .SYM_READY(symReady),
    .SYMBOL(symbol), .LEVEL(level), .OVERFLOW(overflow), .OVF_CLR(ovfClr)
  );

  opcode_trace_decoder #(.DEPTH(DEPTH), .LINE_LEN(LL2)) dutLine (
    .CLOCK(clock), .RST_N(rstN), .OP_VALID(op2Valid), .OPCODE(opcode2),
    .OP_READY(op2Ready), .SYM_VALID(sym2Valid), .SYM_READY(sym2Ready),
    .SYMBOL(symbol2), .LEVEL(level2), .OVERFLOW(overflow2), .OVF_CLR(ovf2Clr)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic rdy, input logic clr);
    opValid  = v;
    opcode   = op;
    symReady = rdy;
    ovfClr   = clr;
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelCol = 0;
    modelNl  = 1'b0;
    modelOvf = 1'b0;
  endtask

  // One clock edge of the trace stream, from the pre-edge state and inputs
  task automatic modelUpdate();
    bit wasFull;
    byte unsigned s;
    wasFull = (modelQ.size() == DEPTH);
    if (!modelNl) begin
      if (modelQ.size() > 0 && symReady) begin
        s = modelQ.pop_front();
        modelOut.push_back(s);
        if (s == 8'h23 || (LL != 0 && modelCol + 1 == LL)) modelNl = 1'b1;
        else modelCol++;
      end
    end else if (symReady) begin
      modelOut.push_back(8'h0A);
      modelNl  = 1'b0;
      modelCol = 0;
    end
    if (opValid && !wasFull && opcode != 4'd0) modelQ.push_back(symTable[opcode]);
    if (opValid && wasFull) modelOvf = 1'b1;
    else if (ovfClr) modelOvf = 1'b0;
  endtask

  task automatic checkAll();
    bit expValid;
    expValid = modelNl || (modelQ.size() > 0);
    checkOutput("level", 32'(level), 32'(modelQ.size()));
    checkOutput("opReady", 32'(opReady), 32'(modelQ.size() < DEPTH));
    checkOutput("overflow", 32'(overflow), 32'(modelOvf));
    checkOutput("symValid", 32'(symValid), 32'(expValid));
    if (expValid) checkOutput("symbol", 32'(symbol), modelNl ? 32'h0A : 32'(modelQ[0]));
  endtask

  // Called just after a falling edge with inputs already applied
  task automatic stepCycle();
    #1;
    if (symValid && symReady) dutOut.push_back(symbol);
    @(posedge clock);
    modelUpdate();
    @(negedge clock);
    checkAll();
  endtask

  task automatic checkStream(input string tag);
    checkOutput($sformatf("%s count", tag), 32'(dutOut.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++) begin
      if (i < dutOut.size()) checkOutput($sformatf("%s sym%0d", tag, i), 32'(dutOut[i]), 32'(expQ[i]));
    end
    dutOut.delete();
    modelOut.delete();
    expQ.delete();
  endtask

  task automatic checkModelStream(input string tag);
    expQ = modelOut;
    checkStream(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pushed;
    int cyc;
    logic [3:0] op;
    byte unsigned got[$];

    // Reset state
    #1 rstN = 1'b0;
    modelReset();
    @(negedge clock);
    checkOutput("reset level", 32'(level), 32'd0);
    checkOutput("reset symValid", 32'(symValid), 32'd0);
    checkOutput("reset symbol", 32'(symbol), 32'h00);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    checkOutput("reset opReady", 32'(opReady), 32'd1);
    @(negedge clock);
    rstN = 1'b1;

    // Basic decode stream ending in HALT and newline
    foreach (symTable[i]) begin end
    applyStimulus(1'b1, 4'd1, 1'b1, 1'b0); stepCycle();
    applyStimulus(1'b1, 4'd3, 1'b1, 1'b0); stepCycle();
    applyStimulus(1'b1, 4'd5, 1'b1, 1'b0); stepCycle();
    applyStimulus(1'b1, 4'd6, 1'b1, 1'b0); stepCycle();
    applyStimulus(1'b1, 4'd9, 1'b1, 1'b0); stepCycle();
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    repeat (6) stepCycle();
    expQ = {8'h2B, 8'h3E, 8'h5B, 8'h5D, 8'h23, 8'h0A};
    checkStream("basic");

    // NOP is never stored, opcode 12 decodes to '?'
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0); stepCycle();
    checkOutput("nop level", 32'(level), 32'd0);
    applyStimulus(1'b1, 4'd12, 1'b0, 1'b0); stepCycle();
    checkOutput("op12 level", 32'(level), 32'd1);
    checkOutput("op12 symbol", 32'(symbol), 32'h3F);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    repeat (3) stepCycle();
    expQ = {8'h3F};
    checkStream("nop");

    // Fill to full, drop one, clear overflow, drain in order
    for (int i = 0; i < 9; i++) begin
      do op = 4'($urandom_range(1, 15)); while (op == 4'd9);
      if (i < DEPTH) expQ.push_back(symTable[op]);
      applyStimulus(1'b1, op, 1'b0, 1'b0);
      stepCycle();
    end
    checkOutput("full level", 32'(level), 32'd8);
    checkOutput("full overflow", 32'(overflow), 32'd1);
    checkOutput("full opReady", 32'(opReady), 32'd0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1); stepCycle();
    checkOutput("ovf cleared", 32'(overflow), 32'd0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    repeat (12) stepCycle();
    checkStream("drain");

    // 20-opcode stream with random backpressure
    pushed = 0;
    cyc = 0;
    while (pushed < 20 && cyc < 400) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), 1'b0);
      if (opValid && opReady) pushed++;
      stepCycle();
      cyc++;
    end
    checkOutput("stream pushes", 32'(pushed), 32'd20);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    repeat (40) stepCycle();
    checkModelStream("stream");

    // Fully random traffic including NOPs, drops and clears
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
      stepCycle();
    end
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    repeat (40) stepCycle();
    checkModelStream("random");

    // Asynchronous reset while in NL with five symbols buffered
    applyStimulus(1'b1, 4'd9, 1'b0, 1'b0); stepCycle();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'd1, 1'b0, 1'b0); stepCycle();
    end
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0); stepCycle();
    checkOutput("nl level", 32'(level), 32'd5);
    checkOutput("nl symbol", 32'(symbol), 32'h0A);
    expQ = {8'h23};
    checkStream("pre reset");
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    #2 rstN = 1'b0;
    modelReset();
    #1;
    checkOutput("async symValid", 32'(symValid), 32'd0);
    checkOutput("async level", 32'(level), 32'd0);
    checkOutput("async overflow", 32'(overflow), 32'd0);
    @(negedge clock);
    rstN = 1'b1;
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b0); stepCycle();
    checkOutput("post reset symbol", 32'(symbol), 32'h2D);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
    repeat (3) stepCycle();
    expQ = {8'h2D};
    checkStream("post reset");

    // Automatic line breaks on the LINE_LEN=4 instance
    pushed = 0;
    cyc = 0;
    while (got.size() < 12 && cyc < 100) begin
      op2Valid  = (pushed < 10);
      opcode2   = 4'd1;
      sym2Ready = 1'b1;
      #1;
      if (sym2Valid && sym2Ready) got.push_back(symbol2);
      if (op2Valid && op2Ready) pushed++;
      @(negedge clock);
      cyc++;
    end
    op2Valid  = 1'b0;
    sym2Ready = 1'b0;
    dutOut = got;
    expQ = {8'h2B, 8'h2B, 8'h2B, 8'h2B, 8'h0A, 8'h2B, 8'h2B, 8'h2B, 8'h2B, 8'h0A, 8'h2B, 8'h2B};
    checkStream("line");
    @(negedge clock);
    checkOutput("line level", 32'(level2), 32'd0);
    checkOutput("line overflow", 32'(overflow2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/opcode_trace_decoder.md
Name: opcode_trace_decoder

Overview:
- Decodes executed 4-bit opcodes back into their source ASCII symbols, the inverse of the instruction encoder, for the console/debug trace of the dekatronpc.
- Sits beside the core. The core strobes each executed opcode in; the block buffers the resulting symbols in a FIFO and streams them to the serial/console sink over a valid/ready handshake.
- Inserts line breaks automatically so the trace is readable.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2 and at least 2.
- LINE_LEN, 64, number of symbols per output line before an automatic 0x0A is emitted; 0 disables automatic breaks.

Ports:
- CLOCK  in  1  system clock; all state changes on its rising edge.
- RST_N  in  1  asynchronous active-low reset.
- OP_VALID  in  1  opcode strobe from the core.
- OPCODE  in  4  executed opcode.
- OP_READY  out  1  high when the FIFO is not full.
- SYM_VALID  out  1  a symbol is presented on SYMBOL.
- SYM_READY  in  1  sink accepts SYMBOL this cycle.
- SYMBOL  out  8  ASCII symbol.
- LEVEL  out  $clog2(DEPTH)+1  current FIFO occupancy.
- OVERFLOW  out  1  sticky flag: an opcode was dropped.
- OVF_CLR  in  1  synchronous clear of OVERFLOW.

Behaviour:
- Reset (RST_N low, asynchronous): FIFO empty, LEVEL=0, OVERFLOW=0, SYM_VALID=0, SYMBOL=0x00, column counter=0, FSM in SYM. OP_READY=1 after reset. Reset mid-transfer discards all buffered symbols.
- Decode table (applied at push):
  - 0 NOP: never stored.
  - 1 '+' (0x2B), 2 '-' (0x2D), 3 '>' (0x3E), 4 '<' (0x3C).
  - 5 '[' (0x5B), 6 ']' (0x5D), 7 '.' (0x2E), 8 ',' (0x2C).
  - 9 HALT '#' (0x23).
  - 10-15: '?' (0x3F).
- Push:
  - Occurs when OP_VALID=1, OP_READY=1 and OPCODE≠0.
  - If OP_VALID=1 and FIFO full, the opcode is dropped and OVERFLOW is set on the next edge.
  - OP_READY is purely !full. It does not account for a same-cycle pop, so a full FIFO never accepts.
- Output is first-word-fall-through. An opcode pushed at edge N into an empty FIFO gives SYM_VALID=1 with its symbol after edge N.
- Transfer occurs when SYM_VALID & SYM_READY. SYMBOL and SYM_VALID are held stable while SYM_READY=0.
- Simultaneous push and pop with the FIFO neither empty nor full: LEVEL is unchanged and order is preserved. Pointers wrap modulo DEPTH.
- FSM:
  - SYM: SYM_VALID = !empty and SYMBOL = FIFO head. On transfer, pop, then:
    - if the popped symbol is '#', go to NL;
    - else if LINE_LEN≠0 and column+1==LINE_LEN, go to NL;
    - else column+1.
  - NL: SYM_VALID=1 and SYMBOL=0x0A regardless of FIFO contents; nothing is popped. On transfer, column=0 and go to SYM.
  - Pushes continue normally in both states.
- OVERFLOW is set on a drop and cleared by OVF_CLR. If a drop and OVF_CLR occur in the same cycle, set wins.
- LEVEL updates on the same edge as push/pop.
- The column counter is wide enough for LINE_LEN.

Test Plan:
- Reset, then push opcodes 1,3,5,6,9 with SYM_READY=1 → SYMBOL sequence 0x2B,0x3E,0x5B,0x5D,0x23,0x0A; the first SYM_VALID appears one cycle after the first push.
- Push opcode 0 and opcode 12 → the NOP produces nothing; 12 yields 0x3F; LEVEL goes 0→0→1.
- SYM_READY=0 while pushing 9 opcodes with DEPTH=8 → OP_READY=0 after 8 pushes, the 9th is dropped, OVERFLOW=1, LEVEL=8. Pulse OVF_CLR → OVERFLOW=0. Release SYM_READY → exactly 8 symbols drain in order.
- LINE_LEN=4, push ten '+' opcodes → output "++++\n++++\n++"; a newline is inserted after the 4th and 8th symbols.
- Toggle SYM_READY randomly during a 20-opcode stream → no loss, no duplication; SYMBOL is stable whenever SYM_VALID=1 and SYM_READY=0.
- Assert RST_N low asynchronously with LEVEL=5 and the FSM in NL → SYM_VALID=0, LEVEL=0, OVERFLOW=0 immediately; after release the first push decodes correctly with column=0.
